// File: rtl/control_fsm_if.sv
// Fetch/datapath-facing bundle of control_fsm: instruction handshake, ALU flags,
// memory completion, and the decoded control strobes.
interface control_fsm_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flag_z;
    logic        flag_c;
    logic        flag_s;
    logic        mem_done;
    logic [2:0]  ALUOp;
    logic [7:0]  func_code;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        pc_write;
    logic        illegal;
    logic        mem_err;
    logic        halted;

    modport master (
        output instr, instr_valid, flag_z, flag_c, flag_s, mem_done,
        input  instr_ready, ALUOp, func_code, alu_src_imm, mem_read, mem_write,
               reg_write, pc_write, illegal, mem_err, halted
    );

    modport slave (
        input  instr, instr_valid, flag_z, flag_c, flag_s, mem_done,
        output instr_ready, ALUOp, func_code, alu_src_imm, mem_read, mem_write,
               reg_write, pc_write, illegal, mem_err, halted
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle KGP-RISC main control: accepts one instruction, decodes it into
// ALUOp/func_code and sequences EXEC, MEM and WB with registered strobes.
module control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    control_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_LOAD, K_STORE, K_BRANCH, K_HALT
    } kind_t;

    localparam logic [2:0] ALUOP_NOP     = 3'b111;
    localparam logic [7:0] MEM_TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [7:0]  func_q, func_d;
    logic [7:0]  mem_cnt_q, mem_cnt_d;
    logic        instr_ready_q, instr_ready_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  func_code_q, func_code_d;
    logic        alu_src_imm_q, alu_src_imm_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        reg_write_q, reg_write_d;
    logic        pc_write_q, pc_write_d;
    logic        illegal_q, illegal_d;
    logic        mem_err_q, mem_err_d;
    logic        halted_q, halted_d;

    logic        func_legal;
    logic        dec_ok;
    kind_t       dec_kind;
    logic [2:0]  dec_alu_op;
    logic [7:0]  dec_func;
    logic        dec_imm;
    logic        br_taken;

    always_comb begin
        case (func_q)
            8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h40, 8'h80: func_legal = 1'b1;
            default:                                          func_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_ok     = 1'b1;
        dec_kind   = K_ALU;
        dec_alu_op = ALUOP_NOP;
        dec_func   = 8'h00;
        dec_imm    = 1'b0;
        case (opcode_q)
            6'd0: begin
                dec_ok     = func_legal;
                dec_alu_op = 3'b000;
                dec_func   = func_q;
            end
            6'd1: begin dec_alu_op = 3'b101; dec_imm = 1'b1; end
            6'd2: begin dec_alu_op = 3'b110; dec_imm = 1'b1; end
            6'd3: dec_alu_op = 3'b010;
            6'd4: dec_alu_op = 3'b011;
            6'd5: dec_alu_op = 3'b100;
            6'd6: begin dec_kind = K_LOAD;  dec_alu_op = 3'b001; dec_imm = 1'b1; end
            6'd7: begin dec_kind = K_STORE; dec_alu_op = 3'b001; dec_imm = 1'b1; end
            6'd16, 6'd17, 6'd18, 6'd19, 6'd20: dec_kind = K_BRANCH;
            6'd63: dec_kind = K_HALT;
            default: dec_ok = 1'b0;
        endcase
    end

    // Branch variant is the low opcode bits: br, bz, bnz, bcy, bltz.
    always_comb begin
        case (opcode_q[2:0])
            3'd0:    br_taken = 1'b1;
            3'd1:    br_taken = bus.flag_z;
            3'd2:    br_taken = !bus.flag_z;
            3'd3:    br_taken = bus.flag_c;
            3'd4:    br_taken = bus.flag_s;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        opcode_d      = opcode_q;
        func_d        = func_q;
        mem_cnt_d     = mem_cnt_q;
        alu_op_d      = alu_op_q;
        func_code_d   = func_code_q;
        alu_src_imm_d = alu_src_imm_q;
        reg_write_d   = 1'b0;
        pc_write_d    = 1'b0;
        illegal_d     = 1'b0;
        mem_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && instr_ready_q) begin
                    opcode_d = bus.instr[31:26];
                    func_d   = bus.instr[7:0];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    state_d       = S_EXEC;
                    kind_d        = dec_kind;
                    alu_op_d      = dec_alu_op;
                    func_code_d   = dec_func;
                    alu_src_imm_d = dec_imm;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_LOAD, K_STORE: begin
                        state_d   = S_MEM;
                        mem_cnt_d = 8'd1;
                    end
                    K_BRANCH: begin
                        pc_write_d = br_taken;
                        state_d    = S_IDLE;
                    end
                    K_HALT:  state_d = S_HALT;
                    default: begin
                        state_d     = S_WB;
                        reg_write_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // A completion on the final allowed cycle wins over the timeout.
                if (bus.mem_done) begin
                    if (kind_q == K_LOAD) begin
                        state_d     = S_WB;
                        reg_write_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (mem_cnt_q >= MEM_TIMEOUT_C) begin
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    mem_cnt_d = mem_cnt_q + 8'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        instr_ready_d = (state_d == S_IDLE);
        if (state_d == S_IDLE) begin
            alu_op_d      = ALUOP_NOP;
            func_code_d   = 8'h00;
            alu_src_imm_d = 1'b0;
        end
        mem_read_d  = (state_d == S_MEM) && (kind_q == K_LOAD);
        mem_write_d = (state_d == S_MEM) && (kind_q == K_STORE);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            kind_q        <= K_ALU;
            opcode_q      <= 6'd0;
            func_q        <= 8'h00;
            mem_cnt_q     <= 8'd0;
            instr_ready_q <= 1'b0;
            alu_op_q      <= ALUOP_NOP;
            func_code_q   <= 8'h00;
            alu_src_imm_q <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            pc_write_q    <= 1'b0;
            illegal_q     <= 1'b0;
            mem_err_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            opcode_q      <= opcode_d;
            func_q        <= func_d;
            mem_cnt_q     <= mem_cnt_d;
            instr_ready_q <= instr_ready_d;
            alu_op_q      <= alu_op_d;
            func_code_q   <= func_code_d;
            alu_src_imm_q <= alu_src_imm_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            pc_write_q    <= pc_write_d;
            illegal_q     <= illegal_d;
            mem_err_q     <= mem_err_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.ALUOp       = alu_op_q;
    assign bus.func_code   = func_code_q;
    assign bus.alu_src_imm = alu_src_imm_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.pc_write    = pc_write_q;
    assign bus.illegal     = illegal_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.halted      = halted_q;

endmodule
